// File: rtl/sequencer.sv
// Polaris instruction sequencer: strobe/ack instruction fetch, IR and execution state for the decoder.
// Optional feature: define POLARIS_ILLEGAL_TRAP_EN to trap undefined instructions to TRAP_VEC.
module sequencer #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter logic [63:0] TRAP_VEC = 64'h100
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        halt_i,
  output logic        istb_o,
  output logic [63:0] iadr_o,
  input  logic        iack_i,
  input  logic [31:0] idat_i,
  output logic [31:0] ir_o,
  output logic [2:0]  cstate_o,
  input  logic [2:0]  nstate_i,
  input  logic        defined_i,
  output logic [63:0] pc_o,
  output logic        retire_o,
  output logic        trap_o,
  output logic [63:0] epc_o
);

  localparam logic [1:0]  PH_IDLE  = 2'd0;
  localparam logic [1:0]  PH_FETCH = 2'd1;
  localparam logic [1:0]  PH_EXEC  = 2'd2;
  localparam logic [2:0]  CS_E0    = 3'd0;
  localparam logic [2:0]  CS_DONE  = 3'd3;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  logic [1:0]  phase_r, phase_n;
  logic [63:0] pc_r, pc_n;
  logic [31:0] ir_r, ir_n;
  logic [2:0]  cstate_r, cstate_n;
  logic        in_exec_s;
  logic        undef_s;
  logic        done_s;
  logic [63:0] pc_inc_s;
  logic [1:0]  after_s;

  assign in_exec_s = (phase_r == PH_EXEC);
  assign undef_s   = in_exec_s && (cstate_r == CS_E0) && !defined_i;
  // An undefined instruction never retires, whatever the decoder proposes.
  assign done_s    = in_exec_s && (nstate_i == CS_DONE) && !undef_s;
  assign pc_inc_s  = pc_r + 64'd4;
  assign after_s   = halt_i ? PH_IDLE : PH_FETCH;

`ifdef POLARIS_ILLEGAL_TRAP_EN
  logic        trap_r, trap_n;
  logic [63:0] epc_r, epc_n;
`else
  logic        unused_trap_vec_s;
  assign unused_trap_vec_s = ^TRAP_VEC;
`endif

  // Next-state logic for phase, PC, IR and execution state.
  always_comb begin
    phase_n  = phase_r;
    pc_n     = pc_r;
    ir_n     = ir_r;
    cstate_n = cstate_r;
`ifdef POLARIS_ILLEGAL_TRAP_EN
    trap_n   = 1'b0;
    epc_n    = epc_r;
`endif
    case (phase_r)
      PH_IDLE: begin
        if (!halt_i) phase_n = PH_FETCH;
        else         phase_n = PH_IDLE;
      end
      PH_FETCH: begin
        if (iack_i) begin
          ir_n     = idat_i;
          cstate_n = CS_E0;
          phase_n  = PH_EXEC;
        end else begin
          phase_n  = PH_FETCH;
        end
      end
      PH_EXEC: begin
        if (undef_s) begin
`ifdef POLARIS_ILLEGAL_TRAP_EN
          pc_n   = TRAP_VEC;
          epc_n  = pc_r;
          trap_n = 1'b1;
`else
          pc_n   = pc_inc_s;
`endif
          cstate_n = CS_DONE;
          phase_n  = after_s;
        end else if (done_s) begin
          pc_n     = pc_inc_s;
          cstate_n = CS_DONE;
          phase_n  = after_s;
        end else begin
          cstate_n = nstate_i;
        end
      end
      default: begin
        phase_n  = PH_IDLE;
        cstate_n = CS_DONE;
      end
    endcase
  end

  // State registers with asynchronous reset to the architectural reset values.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      phase_r  <= PH_IDLE;
      pc_r     <= RESET_PC;
      ir_r     <= NOP_INSN;
      cstate_r <= CS_DONE;
`ifdef POLARIS_ILLEGAL_TRAP_EN
      trap_r   <= 1'b0;
      epc_r    <= 64'h0;
`endif
    end else begin
      phase_r  <= phase_n;
      pc_r     <= pc_n;
      ir_r     <= ir_n;
      cstate_r <= cstate_n;
`ifdef POLARIS_ILLEGAL_TRAP_EN
      trap_r   <= trap_n;
      epc_r    <= epc_n;
`endif
    end
  end

  assign istb_o   = (phase_r == PH_FETCH);
  assign iadr_o   = pc_r;
  assign pc_o     = pc_r;
  assign ir_o     = ir_r;
  assign cstate_o = cstate_r;
  assign retire_o = done_s;
`ifdef POLARIS_ILLEGAL_TRAP_EN
  assign trap_o   = trap_r;
  assign epc_o    = epc_r;
`else
  assign trap_o   = 1'b0;
  assign epc_o    = 64'h0;
`endif

endmodule

// File: tb/tb_sequencer.sv
// Scoreboard bench for sequencer: stimulus pushes expected fetch/retire/trap events, a monitor pops them.
module tb_sequencer;

  localparam logic [63:0] RESET_PC = 64'h0;
  localparam logic [63:0] TRAP_VEC = 64'h100;
  localparam logic [31:0] NOP_W    = 32'h0000_0013;
  localparam logic [31:0] UNDEF_W  = 32'h0010_0000;
`ifdef POLARIS_ILLEGAL_TRAP_EN
  localparam logic [63:0] AFTER_UNDEF = TRAP_VEC;
`else
  localparam logic [63:0] AFTER_UNDEF = 64'd12;
`endif
  localparam int K_FETCH  = 0;
  localparam int K_RETIRE = 1;
  localparam int K_TRAP   = 2;

  logic        clk;
  logic        reset_i;
  logic        halt_i;
  logic        istb_o;
  logic [63:0] iadr_o;
  logic        iack_i;
  logic [31:0] idat_i;
  logic [31:0] ir_o;
  logic [2:0]  cstate_o;
  logic [2:0]  nstate_i;
  logic        defined_i;
  logic [63:0] pc_o;
  logic        retire_o;
  logic        trap_o;
  logic [63:0] epc_o;

  sequencer #(.RESET_PC(RESET_PC), .TRAP_VEC(TRAP_VEC)) dut (
    .clk_i(clk), .reset_i(reset_i), .halt_i(halt_i),
    .istb_o(istb_o), .iadr_o(iadr_o), .iack_i(iack_i), .idat_i(idat_i),
    .ir_o(ir_o), .cstate_o(cstate_o), .nstate_i(nstate_i), .defined_i(defined_i),
    .pc_o(pc_o), .retire_o(retire_o), .trap_o(trap_o), .epc_o(epc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] c;
  } ev_t;

  ev_t sb_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  stall;
  int  istb_cnt;
  int  exec_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory image: ADDI x(rd),x0,0x42 everywhere, with rd derived from the address, and one undefined word at 8.
  function automatic logic [31:0] word_at(input logic [63:0] a);
    logic [4:0] rd;
    rd = a[6:2] + 5'd1;
    if (a == 64'd8) return UNDEF_W;
    return 32'h0420_0013 | {20'h0, rd, 7'h0};
  endfunction

  function automatic int waits_at(input logic [63:0] a);
    return (a == 64'd4) ? 3 : 0;
  endfunction

  // Bus and decoder models.
  always_comb begin
    idat_i    = word_at(iadr_o);
    iack_i    = istb_o && (stall >= waits_at(iadr_o));
    nstate_i  = ((cstate_o == 3'd2) || (cstate_o == 3'd3)) ? 3'd3 : cstate_o + 3'd1;
    defined_i = (ir_o != UNDEF_W);
  end

  always @(posedge clk or negedge reset_i) begin
    if (!reset_i)                 stall <= 0;
    else if (istb_o && !iack_i)   stall <= stall + 1;
    else                          stall <= 0;
  end

  task automatic push(input int k, input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    ev_t e;
    e.kind = k; e.a = a; e.b = b; e.c = c;
    sb_q.push_back(e);
  endtask

  task automatic observe(input int k, input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    ev_t e;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_event: got kind %0d addr %0h, expected no event", k, a);
    end else begin
      e = sb_q.pop_front();
      chk("event_kind", k, e.kind);
      chk((k == K_FETCH) ? "fetch_addr" : (k == K_RETIRE) ? "retire_pc" : "trap_epc", a, e.a);
      chk((k == K_FETCH) ? "fetch_istb_cycles" : (k == K_RETIRE) ? "retire_exec_cycles" : "trap_pc", b, e.b);
      chk((k == K_FETCH) ? "fetch_ir_before" : (k == K_RETIRE) ? "retire_cstate" : "trap_cstate", c, e.c);
    end
  endtask

  // Monitor: turns DUT output activity into events and checks them against the scoreboard.
  initial begin
    istb_cnt = 0;
    exec_cnt = 0;
    forever begin
      @(negedge clk);
      if (!reset_i) begin
        istb_cnt = 0;
        exec_cnt = 0;
      end else begin
        if (istb_o) istb_cnt++;
        if (cstate_o != 3'd3) exec_cnt++;
        if (trap_o) observe(K_TRAP, epc_o, pc_o, {61'h0, cstate_o});
        if (retire_o) observe(K_RETIRE, pc_o, exec_cnt, {61'h0, cstate_o});
        if (istb_o && iack_i) begin
          observe(K_FETCH, iadr_o, istb_cnt, {32'h0, ir_o});
          istb_cnt = 0;
          exec_cnt = 0;
        end
      end
    end
  end

  task automatic wait_e1(input logic [63:0] pc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #2;
      if (pc_o == pc && cstate_o == 3'd1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit ok;
    reset_i = 1'b1;
    halt_i  = 1'b0;
    #2 reset_i = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_pc", pc_o, RESET_PC);
    chk("rst_iadr", iadr_o, RESET_PC);
    chk("rst_ir", ir_o, NOP_W);
    chk("rst_cstate", cstate_o, 3'd3);
    chk("rst_istb", istb_o, 1'b0);
    chk("rst_retire", retire_o, 1'b0);
    chk("rst_trap", trap_o, 1'b0);
    chk("rst_epc", epc_o, 64'h0);

    push(K_FETCH, 64'd0, 64'd1, NOP_W);
    push(K_RETIRE, 64'd0, 64'd3, 64'd2);
    push(K_FETCH, 64'd4, 64'd4, word_at(64'd0));
    push(K_RETIRE, 64'd4, 64'd3, 64'd2);
    push(K_FETCH, 64'd8, 64'd1, word_at(64'd4));
`ifdef POLARIS_ILLEGAL_TRAP_EN
    push(K_TRAP, 64'd8, TRAP_VEC, 64'd3);
`endif
    push(K_FETCH, AFTER_UNDEF, 64'd1, UNDEF_W);
    push(K_RETIRE, AFTER_UNDEF, 64'd3, 64'd2);
    reset_i = 1'b1;

    @(negedge clk);
    chk("idle_cycle_istb", istb_o, 1'b0);
    @(negedge clk);
    chk("first_fetch_istb", istb_o, 1'b1);
    chk("first_fetch_cstate", cstate_o, 3'd3);

    // Halt raised in E1: the instruction retires, then the sequencer parks in IDLE.
    wait_e1(AFTER_UNDEF, ok);
    chk("reach_e1_halt", ok, 1'b1);
    halt_i = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    chk("halt_istb", istb_o, 1'b0);
    chk("halt_pc", pc_o, AFTER_UNDEF + 64'd4);
    chk("halt_cstate", cstate_o, 3'd3);
    repeat (2) @(posedge clk);
    #2;
    chk("halt_istb_hold", istb_o, 1'b0);
    push(K_FETCH, AFTER_UNDEF + 64'd4, 64'd1, word_at(AFTER_UNDEF));
    halt_i = 1'b0;

    // Asynchronous reset in the middle of an instruction.
    wait_e1(AFTER_UNDEF + 64'd4, ok);
    chk("reach_e1_reset", ok, 1'b1);
    reset_i = 1'b0;
    #1;
    chk("async_cstate", cstate_o, 3'd3);
    chk("async_pc", pc_o, RESET_PC);
    chk("async_iadr", iadr_o, RESET_PC);
    chk("async_ir", ir_o, NOP_W);
    chk("async_istb", istb_o, 1'b0);
    chk("async_epc", epc_o, 64'h0);
    push(K_FETCH, RESET_PC, 64'd1, NOP_W);
    push(K_RETIRE, RESET_PC, 64'd3, 64'd2);
    @(posedge clk);
    #2 reset_i = 1'b1;

    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #2;
      if (sb_q.size() == 0) break;
    end
    chk("scoreboard_drained", sb_q.size(), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sequencer.md
# sequencer

Instruction sequencer for the Polaris core: fetches 32-bit instructions over a simple strobe/acknowledge bus, holds the instruction register and the 3-bit execution state that feed the instruction decoder, and advances that state from the decoder's next-state output. It maintains the program counter, signals instruction retirement, and redirects fetch on undefined instructions. It sits between the instruction bus and the decoder/datapath.

## Interface
- `RESET_PC`, default 64'h0: PC loaded on reset.
- `TRAP_VEC`, default 64'h100: PC loaded when an undefined instruction traps.
- `clk_i` in 1: clock; all state changes on the rising edge.
- `reset_i` in 1: asynchronous, active-low reset.
- `halt_i` in 1: 1 = stop at the next instruction boundary.
- `istb_o` out 1: fetch request.
- `iadr_o` out 64: fetch address; always equals `pc_o`.
- `iack_i` in 1: fetch acknowledge; `idat_i` is valid in the same cycle.
- `idat_i` in 32: fetched instruction word.
- `ir_o` out 32: instruction register, drives decoder `ir_i`.
- `cstate_o` out 3: execution state, drives decoder `cstate_i`.
- `nstate_i` in 3: decoder next state.
- `defined_i` in 1: decoder reports that the instruction is defined.
- `pc_o` out 64: address of the current instruction.
- `retire_o` out 1: the instruction completes this cycle.
- `trap_o` out 1: one-cycle trap pulse.
- `epc_o` out 64: PC of the last trapping instruction.

## Operation
- The sequencer has three phases: IDLE, FETCH and EXEC. In IDLE and FETCH, `cstate_o` = 3, so all decoder execute minterms are inactive.
- **Reset.**
  - Phase = IDLE.
  - `pc_o` = `iadr_o` = `RESET_PC`.
  - `ir_o` = 32'h0000_0013 (NOP).
  - `cstate_o` = 3.
  - `istb_o`, `retire_o` and `trap_o` = 0; `epc_o` = 0.
- **IDLE.** Go to FETCH on the next edge when `halt_i` = 0; otherwise stay in IDLE.
- **FETCH.**
  - `istb_o` = 1.
  - When `iack_i` = 1: `ir_o` <= `idat_i`, `cstate_o` <= 0, phase <= EXEC.
  - Once asserted, `istb_o` stays high until acknowledged; `halt_i` cannot withdraw it.
  - `iack_i` is ignored whenever `istb_o` = 0.
- **EXEC, `cstate_o` = 0.**
  - If `defined_i` = 0, take the undefined path (see Configuration).
  - Otherwise `cstate_o` <= `nstate_i`.
- **EXEC, `cstate_o` 1 or 2.** `cstate_o` <= `nstate_i`.
- **End of instruction.** When `nstate_i` = 3 in EXEC:
  - `retire_o` = 1 in that cycle (combinational from phase, `cstate_o` and `nstate_i`).
  - Next edge: `pc_o` <= `pc_o` + 4 (modulo 2^64), `cstate_o` <= 3.
  - Phase <= FETCH if `halt_i` = 0, else IDLE.
- `ir_o` changes only on a fetch acknowledge.

## Timing
- Zero-wait-state bus (`iack_i` in the first `istb_o` cycle), OP-IMM instruction, 4 cycles per instruction:
  - F: `istb_o` = 1, `iack_i` = 1.
  - E0: `cstate_o` = 0.
  - E1: `cstate_o` = 1.
  - E2: `cstate_o` = 2, `retire_o` = 1.
  - Next cycle is F for the following instruction.
- Each bus wait cycle adds one F cycle.
- Reset to first `istb_o`: one IDLE cycle after `reset_i` deasserts.
- `reset_i` asserted mid-fetch or mid-execute: all outputs take their reset values immediately, without waiting for a clock edge.
- `halt_i` rising during EXEC: the current instruction completes and retires, then the sequencer enters IDLE with `pc_o` pointing at the next instruction.
- `trap_o` is registered: high for exactly the first cycle after the trapping E0 cycle.

## Configuration
- Macro `POLARIS_ILLEGAL_TRAP_EN`.
- **Defined.** Undefined instruction in E0:
  - Next edge: `epc_o` <= `pc_o`, `pc_o` <= `TRAP_VEC`, `cstate_o` <= 3.
  - `trap_o` = 1 for one cycle; no `retire_o`.
  - Then FETCH or IDLE according to `halt_i`.
- **Not defined.** Undefined instruction in E0:
  - Treated as a NOP: `pc_o` <= `pc_o` + 4, `cstate_o` <= 3, no `retire_o`.
  - `trap_o` and `epc_o` are tied to 0.
  - Port list is unchanged.

## Test plan
- **Reset and first fetch.** Pulse `reset_i` low with `RESET_PC` = 0; bus always acks with ADDI X1,X0,$042 (32'h0420_0093) -> `iadr_o` = 0; `cstate_o` sequence 3,3,0,1,2,3; `retire_o` high only in the `cstate_o` = 2 cycle; then `iadr_o` = 4.
- **Wait states.** Hold `iack_i` low for 3 cycles -> `istb_o` stays high for 4 cycles and `ir_o` stays unchanged until the ack.
- **Undefined instruction with the macro defined.** `idat_i` = 32'h0010_0000 at PC 8 -> `trap_o` pulses once; `epc_o` = 8; next `iadr_o` = 32'h100; `retire_o` stays 0.
- **Undefined instruction without the macro.** Same stimulus -> `trap_o` = 0; next `iadr_o` = 12.
- **Halt.** Assert `halt_i` during E1 -> the instruction retires, the sequencer sits in IDLE with `istb_o` = 0; releasing `halt_i` -> fetch resumes at PC + 4.
- **Reset mid-execute.** Drop `reset_i` in E1 -> `cstate_o` = 3, `pc_o` = `RESET_PC` and `ir_o` = 32'h13 immediately, before the next clock edge.
